ddr3_req_queue: RTL and testbench
=================================

Name: ddr3_req_queue

Overview:
- CPU-side request buffer that sits directly upstream of the DDR3 memory controller.
- Accepts tagged read/write requests from the CPU through a valid/ready handshake and holds them in a DEPTH-entry FIFO.
- Issues requests in order to the controller using the controller's CMD_RDY/ADDR_VALID handshake.
- Returns read data to the CPU with the original tag after a fixed read latency; also keeps row-hit/miss statistics.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.
- TAG_W, 4, width of the request/response tag.
- RD_LAT, 6, cycles from an accepted read handshake to rsp_valid; must be at least 1.

Ports:
- cpu_clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  queue can accept a request.
- req_cmd  in  1  1 = read, 0 = write.
- req_ba  in  3  bank address.
- req_row  in  15  row address.
- req_col  in  10  column address.
- req_wdata  in  64  write burst data (8 beats x 8 bits).
- req_tag  in  TAG_W  request tag.
- rsp_valid  out  1  read response valid, one-cycle pulse.
- rsp_tag  out  TAG_W  tag of the returned read.
- rsp_data  out  64  read burst data.
- mc_cmd_rdy  in  1  controller ready (CMD_RDY).
- mc_addr_valid  out  1  head request valid (ADDR_VALID).
- mc_cmd  out  1  head command (CMD).
- mc_ba  out  3  head bank (BA).
- mc_addr  out  15  head row (ADDR).
- mc_col  out  10  head column (COL).
- mc_wr_data  out  64  head write data (WR_DATA).
- mc_rd_data  in  64  controller read data (RD_DATA).
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- row_hit_cnt  out  16  issued requests whose bank and row match the previous issued request; saturating.
- row_miss_cnt  out  16  issued requests that do not match; saturating.

Behaviour:
- Reset (async, reset_n low):
  - write pointer, read pointer and count go to 0; the read pipeline is cleared.
  - rsp_valid=0, rsp_tag=0, rsp_data=0; both statistics counters=0.
  - The "previous row valid" flag is cleared.
  - Any requests in the FIFO or reads in flight are discarded; no response is produced for them.
- req_ready = (count != DEPTH), combinational from registered count.
- Push occurs when req_valid && req_ready; the entry is stored {cmd, ba, row, col, wdata, tag}.
- mc_addr_valid = (count != 0). All mc_* fields are driven combinationally from the head entry. When the FIFO is empty, mc_* fields must be held at 0.
- Pop occurs when mc_addr_valid && mc_cmd_rdy in the same cycle; the read pointer advances.
- Latency:
  - A request pushed in cycle N into an empty FIFO is visible on mc_* in cycle N+1.
  - There is no bypass path.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - When full, req_ready=0, so a pop in that cycle does not allow a same-cycle push.
  - When count==1, a simultaneous push and pop leaves count at 1 and the new entry becomes the head.
- Pointers wrap modulo DEPTH; count saturates at neither end, since its legal range is 0..DEPTH.
- Read return pipeline:
  - A popped read (mc_cmd=1) in cycle N enters an RD_LAT-stage shift register carrying {valid, tag}.
  - In cycle N+RD_LAT: rsp_valid=1, rsp_tag=tag, rsp_data = the mc_rd_data value sampled at the rising edge that ends cycle N+RD_LAT-1. All three are registered.
  - Popped writes produce no response.
  - Back-to-back reads produce responses in issue order; each response is a one-cycle pulse.
- Statistics, updated on each pop:
  - If the previous-row-valid flag is set and {ba,row} equals the last issued {ba,row}, increment row_hit_cnt; otherwise increment row_miss_cnt.
  - Then store {ba,row} as the last issued value and set the flag.
  - The first pop after reset always counts as a miss.
  - Both counters stop at 16'hFFFF.
- mc_cmd_rdy may drop while mc_addr_valid is high: the head is held stable and no pop occurs.

Test Plan:
- Reset, then push a write {ba=1,row=0x0010,col=0x008,wdata=0x0123456789ABCDEF,tag=3} with mc_cmd_rdy=1 -> mc_addr_valid high the cycle after the push with matching fields; popped on that cycle; fifo_count back to 0; no rsp_valid; row_miss_cnt=1.
- Push 5 requests with mc_cmd_rdy=0 -> req_ready drops after the 4th; fifo_count=4; the 5th is accepted only after the first pop; issue order is preserved.
- Read {ba=2,row=0x0020,tag=9} popped in cycle N; drive mc_rd_data=0xDEADBEEFCAFEF00D in cycle N+5 -> rsp_valid pulse in cycle N+6 with rsp_tag=9 and that data.
- Three consecutive pops to the same {ba,row}, then one to a different row -> row_hit_cnt=2, row_miss_cnt=2.
- Assert reset_n low while 3 entries are queued and a read is in flight -> fifo_count=0, mc_addr_valid=0, no rsp_valid after release, counters=0.
- Hold count=1 with simultaneous push and pop for 10 cycles -> fifo_count stays 1; pointers wrap correctly; all 10 requests are issued in order.

Source files
------------

// File: rtl/ddr3_req_queue.sv
// ddr3_req_queue: CPU-side request FIFO in front of the DDR3 controller.
// Buffers tagged read/write requests, issues them in order over the
// CMD_RDY/ADDR_VALID handshake, returns read data after a fixed latency and
// keeps saturating row-hit/miss statistics for issued requests.
module ddr3_req_queue #(
   parameter int DEPTH  = 4,
   parameter int TAG_W  = 4,
   parameter int RD_LAT = 6
) (
   input  logic                     cpu_clk,
   input  logic                     reset_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_cmd,
   input  logic [2:0]               req_ba,
   input  logic [14:0]              req_row,
   input  logic [9:0]               req_col,
   input  logic [63:0]              req_wdata,
   input  logic [TAG_W-1:0]         req_tag,
   output logic                     rsp_valid,
   output logic [TAG_W-1:0]         rsp_tag,
   output logic [63:0]              rsp_data,
   input  logic                     mc_cmd_rdy,
   output logic                     mc_addr_valid,
   output logic                     mc_cmd,
   output logic [2:0]               mc_ba,
   output logic [14:0]              mc_addr,
   output logic [9:0]               mc_col,
   output logic [63:0]              mc_wr_data,
   input  logic [63:0]              mc_rd_data,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [15:0]              row_hit_cnt,
   output logic [15:0]              row_miss_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic             cmd;
      logic [2:0]       ba;
      logic [14:0]      row;
      logic [9:0]       col;
      logic [63:0]      wdata;
      logic [TAG_W-1:0] tag;
   } entry_t;

   entry_t            mem_q [DEPTH];
   entry_t            wr_entry;
   entry_t            head;

   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              push, pop, issue_rd;

   logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
   logic [TAG_W-1:0]  pipe_tag_q [RD_LAT];
   logic [TAG_W-1:0]  pipe_tag_d [RD_LAT];
   logic [RD_LAT-1:0] in_vld;
   logic [TAG_W-1:0]  in_tag [RD_LAT];
   logic [63:0]       rsp_data_q, rsp_data_d;

   logic [17:0]       head_key;
   logic [17:0]       last_key_q, last_key_d;
   logic              prev_vld_q, prev_vld_d;
   logic [15:0]       hit_q, hit_d;
   logic [15:0]       miss_q, miss_d;

   // Handshakes, head-entry presentation and the controller-facing fields
   always_comb begin
      req_ready     = (count_q != CW'(DEPTH));
      mc_addr_valid = (count_q != '0);
      push          = req_valid && req_ready;
      pop           = mc_addr_valid && mc_cmd_rdy;
      head          = mc_addr_valid ? mem_q[rd_ptr_q] : '0;
      issue_rd      = pop && head.cmd;
      head_key      = {head.ba, head.row};
      wr_entry      = '{cmd: req_cmd, ba: req_ba, row: req_row, col: req_col,
                        wdata: req_wdata, tag: req_tag};
      mc_cmd        = head.cmd;
      mc_ba         = head.ba;
      mc_addr       = head.row;
      mc_col        = head.col;
      mc_wr_data    = head.wdata;
      fifo_count    = count_q;
      row_hit_cnt   = hit_q;
      row_miss_cnt  = miss_q;
      rsp_valid     = pipe_vld_q[RD_LAT-1];
      rsp_tag       = pipe_tag_q[RD_LAT-1];
      rsp_data      = rsp_data_q;
   end

   // Pointer and occupancy next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Read-return shift register; the last stage doubles as the response
   // register, so its tag and the captured data hold between responses
   always_comb begin
      in_vld     = '0;
      in_tag     = '{default: '0};
      in_vld[0]  = issue_rd;
      in_tag[0]  = head.tag;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
         in_vld[i] = pipe_vld_q[i-1];
         in_tag[i] = pipe_tag_q[i-1];
      end
      pipe_vld_d = in_vld;
      pipe_tag_d = in_tag;
      if (!in_vld[RD_LAT-1]) pipe_tag_d[RD_LAT-1] = pipe_tag_q[RD_LAT-1];
      rsp_data_d = in_vld[RD_LAT-1] ? mc_rd_data : rsp_data_q;
   end

   // Row-hit/miss statistics, evaluated against the previously issued bank/row
   always_comb begin
      hit_d      = hit_q;
      miss_d     = miss_q;
      last_key_d = last_key_q;
      prev_vld_d = prev_vld_q;
      if (pop) begin
         if (prev_vld_q && (head_key == last_key_q)) begin
            if (hit_q != 16'hFFFF) hit_d = hit_q + 16'd1;
         end else begin
            if (miss_q != 16'hFFFF) miss_d = miss_q + 16'd1;
         end
         last_key_d = head_key;
         prev_vld_d = 1'b1;
      end
   end

   // Entry storage; contents need no reset since occupancy gates visibility
   always_ff @(posedge cpu_clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_entry;
   end

   // Control, pipeline and statistics registers
   always_ff @(posedge cpu_clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         pipe_vld_q <= '0;
         pipe_tag_q <= '{default: '0};
         rsp_data_q <= '0;
         last_key_q <= '0;
         prev_vld_q <= 1'b0;
         hit_q      <= '0;
         miss_q     <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         pipe_vld_q <= pipe_vld_d;
         pipe_tag_q <= pipe_tag_d;
         rsp_data_q <= rsp_data_d;
         last_key_q <= last_key_d;
         prev_vld_q <= prev_vld_d;
         hit_q      <= hit_d;
         miss_q     <= miss_d;
      end
   end

endmodule

// File: tb/tb_ddr3_req_queue.sv
// Bench for ddr3_req_queue: directed scenarios followed by random traffic,
// all checked every cycle against a queue-based reference model.
module tb_ddr3_req_queue;

   localparam int DEPTH  = 4;
   localparam int TAG_W  = 4;
   localparam int RD_LAT = 6;
   localparam int CW     = $clog2(DEPTH) + 1;

   logic              cpu_clk = 1'b0;
   logic              reset_n;
   logic              req_valid, req_ready, req_cmd;
   logic [2:0]        req_ba;
   logic [14:0]       req_row;
   logic [9:0]        req_col;
   logic [63:0]       req_wdata;
   logic [TAG_W-1:0]  req_tag;
   logic              rsp_valid;
   logic [TAG_W-1:0]  rsp_tag;
   logic [63:0]       rsp_data;
   logic              mc_cmd_rdy, mc_addr_valid, mc_cmd;
   logic [2:0]        mc_ba;
   logic [14:0]       mc_addr;
   logic [9:0]        mc_col;
   logic [63:0]       mc_wr_data, mc_rd_data;
   logic [CW-1:0]     fifo_count;
   logic [15:0]       row_hit_cnt, row_miss_cnt;

   ddr3_req_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .RD_LAT(RD_LAT)) dut (
      .cpu_clk(cpu_clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
      .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
      .req_wdata(req_wdata), .req_tag(req_tag),
      .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
      .mc_cmd_rdy(mc_cmd_rdy), .mc_addr_valid(mc_addr_valid), .mc_cmd(mc_cmd),
      .mc_ba(mc_ba), .mc_addr(mc_addr), .mc_col(mc_col),
      .mc_wr_data(mc_wr_data), .mc_rd_data(mc_rd_data),
      .fifo_count(fifo_count), .row_hit_cnt(row_hit_cnt),
      .row_miss_cnt(row_miss_cnt)
   );

   always #5 cpu_clk = ~cpu_clk;

   typedef struct {
      bit               cmd;
      bit [2:0]         ba;
      bit [14:0]        row;
      bit [9:0]         col;
      bit [63:0]        wdata;
      bit [TAG_W-1:0]   tag;
   } req_t;

   typedef struct {
      int               due;
      bit [TAG_W-1:0]   tag;
   } rsp_t;

   // Reference model state
   req_t              mq[$];
   rsp_t              pend[$];
   logic [63:0]       rd_hist[int];
   int                cyc = 0;
   bit                m_prev_vld;
   bit [17:0]         m_last_key;
   int                m_hit, m_miss;
   bit [TAG_W-1:0]    m_rsp_tag;
   bit [63:0]         m_rsp_data;

   int                total = 0;
   int                bad   = 0;
   int                n_mark;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      pend.delete();
      m_prev_vld = 0;
      m_last_key = '0;
      m_hit      = 0;
      m_miss     = 0;
      m_rsp_tag  = '0;
      m_rsp_data = '0;
   endtask

   task automatic check_outputs();
      req_t h;
      bit   ne, ev;
      ne = (mq.size() != 0);
      h  = '{default: 0};
      if (ne) h = mq[0];
      chk("req_ready",     req_ready,     64'(mq.size() != DEPTH));
      chk("mc_addr_valid", mc_addr_valid, 64'(ne));
      chk("mc_cmd",        mc_cmd,        64'(h.cmd));
      chk("mc_ba",         mc_ba,         64'(h.ba));
      chk("mc_addr",       mc_addr,       64'(h.row));
      chk("mc_col",        mc_col,        64'(h.col));
      chk("mc_wr_data",    mc_wr_data,    h.wdata);
      chk("fifo_count",    fifo_count,    64'(mq.size()));
      chk("row_hit_cnt",   row_hit_cnt,   64'(m_hit));
      chk("row_miss_cnt",  row_miss_cnt,  64'(m_miss));
      ev = (pend.size() != 0) && (pend[0].due == cyc);
      if (ev) begin
         m_rsp_tag  = pend[0].tag;
         m_rsp_data = rd_hist[cyc-1];
         pend.delete(0);
      end
      chk("rsp_valid", rsp_valid, 64'(ev));
      chk("rsp_tag",   rsp_tag,   64'(m_rsp_tag));
      chk("rsp_data",  rsp_data,  m_rsp_data);
   endtask

   // One clock cycle: apply model rules to the inputs driven this cycle,
   // advance, then compare every output against the model
   task automatic tick();
      bit   push, pop;
      req_t e, h;
      push = req_valid && (mq.size() != DEPTH);
      pop  = (mq.size() != 0) && mc_cmd_rdy;
      e = '{cmd: req_cmd, ba: req_ba, row: req_row, col: req_col,
            wdata: req_wdata, tag: req_tag};
      rd_hist[cyc] = mc_rd_data;
      @(posedge cpu_clk);
      #1;
      cyc++;
      if (!reset_n) begin
         model_clear();
      end else begin
         if (pop) begin
            h = mq.pop_front();
            if (h.cmd) pend.push_back('{due: cyc - 1 + RD_LAT, tag: h.tag});
            if (m_prev_vld && ({h.ba, h.row} == m_last_key)) begin
               if (m_hit < 65535) m_hit++;
            end else begin
               if (m_miss < 65535) m_miss++;
            end
            m_last_key = {h.ba, h.row};
            m_prev_vld = 1;
         end
         if (push) mq.push_back(e);
      end
      check_outputs();
      mc_rd_data = {$urandom, $urandom};
   endtask

   task automatic set_req(input bit c, input bit [2:0] ba, input bit [14:0] row,
                          input bit [9:0] col, input bit [63:0] wd, input bit [TAG_W-1:0] tg);
      req_valid = 1'b1;
      req_cmd   = c;
      req_ba    = ba;
      req_row   = row;
      req_col   = col;
      req_wdata = wd;
      req_tag   = tg;
   endtask

   task automatic set_rand_req(input bit [TAG_W-1:0] tg);
      set_req(1'($urandom), 3'($urandom_range(0, 1)), 15'($urandom_range(0, 1)),
              10'($urandom), {$urandom, $urandom}, tg);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #2;
      model_clear();
      chk("rst_fifo_count", fifo_count,    '0);
      chk("rst_addr_valid", mc_addr_valid, '0);
      chk("rst_rsp_valid",  rsp_valid,     '0);
      chk("rst_hit",        row_hit_cnt,   '0);
      chk("rst_miss",       row_miss_cnt,  '0);
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n    = 1'b0;
      req_valid  = 1'b0;
      req_cmd    = 1'b0;
      req_ba     = '0;
      req_row    = '0;
      req_col    = '0;
      req_wdata  = '0;
      req_tag    = '0;
      mc_cmd_rdy = 1'b0;
      mc_rd_data = '0;
      model_clear();
      repeat (3) @(posedge cpu_clk);
      #1;
      check_outputs();
      reset_n = 1'b1;

      // Single write, controller ready
      mc_cmd_rdy = 1'b1;
      set_req(0, 3'd1, 15'h0010, 10'h008, 64'h0123456789ABCDEF, 4'd3);
      tick();
      req_valid = 1'b0;
      chk("t1_addr_valid", mc_addr_valid, 64'd1);
      chk("t1_mc_wr_data", mc_wr_data, 64'h0123456789ABCDEF);
      tick();
      chk("t1_count", fifo_count, '0);
      chk("t1_miss", row_miss_cnt, 64'd1);
      repeat (RD_LAT + 1) tick();

      // Fill to full with the controller stalled, then release it
      mc_cmd_rdy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         set_rand_req(4'(k));
         tick();
      end
      set_rand_req(4'd4);
      tick();
      chk("t2_full_ready", req_ready, '0);
      chk("t2_full_count", fifo_count, 64'd4);
      tick();
      mc_cmd_rdy = 1'b1;
      tick();
      tick();
      req_valid = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      chk("t2_drained", fifo_count, '0);

      // Read latency with a marked data word
      set_req(1, 3'd2, 15'h0020, 10'h011, 64'h0, 4'd9);
      tick();
      req_valid = 1'b0;
      n_mark = cyc;
      tick();
      while (cyc < n_mark + RD_LAT - 1) tick();
      mc_rd_data = 64'hDEADBEEFCAFEF00D;
      tick();
      chk("t3_rsp_valid", rsp_valid, 64'd1);
      chk("t3_rsp_tag", rsp_tag, 64'd9);
      chk("t3_rsp_data", rsp_data, 64'hDEADBEEFCAFEF00D);
      tick();
      chk("t3_pulse_end", rsp_valid, '0);

      // Row-hit statistics from a clean reset
      do_reset();
      for (int k = 0; k < 4; k++) begin
         set_req(0, 3'd5, (k == 3) ? 15'h0124 : 15'h0123, 10'(k), 64'(k), 4'(k));
         tick();
      end
      req_valid = 1'b0;
      repeat (3) tick();
      chk("t4_hit", row_hit_cnt, 64'd2);
      chk("t4_miss", row_miss_cnt, 64'd2);

      // Reset while entries are queued and a read is in flight
      set_req(1, 3'd3, 15'h0042, 10'h001, 64'h0, 4'd7);
      tick();
      req_valid = 1'b0;
      tick();
      mc_cmd_rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_rand_req(4'(k + 10));
         tick();
      end
      req_valid = 1'b0;
      chk("t5_pre_count", fifo_count, 64'd3);
      do_reset();
      repeat (RD_LAT + 3) tick();

      // Sustained push+pop at occupancy one
      set_rand_req(4'd0);
      tick();
      mc_cmd_rdy = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         set_rand_req(4'(k));
         tick();
         chk("t6_count1", fifo_count, 64'd1);
      end
      req_valid = 1'b0;
      repeat (RD_LAT + 2) tick();

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 3) != 0) set_rand_req(4'($urandom));
         else req_valid = 1'b0;
         mc_cmd_rdy = ($urandom_range(0, 3) != 0);
         tick();
      end
      req_valid  = 1'b0;
      mc_cmd_rdy = 1'b1;
      repeat (DEPTH + RD_LAT + 2) tick();
      chk("final_empty", fifo_count, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
